// File: rtl/neuron_core_fabric.sv
// rtl/neuron_core_fabric.sv - Wishbone fabric fanning one master out to neuron slices with broadcast, status and timeout
module neuron_core_fabric #(
  parameter int          NUM_SLICE = 8,
  parameter logic [31:0] CORE_BASE = 32'h3000_0000,
  parameter logic [11:0] SPIKE_OFS = 12'h600,
  parameter int          TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [NUM_SLICE-1:0]   s_cyc_o,
  output logic [NUM_SLICE-1:0]   s_stb_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [11:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  input  logic [NUM_SLICE-1:0]   s_ack_i,
  input  logic [32*NUM_SLICE-1:0] s_dat_i,
  output logic                   picture_done
);

  typedef enum logic [1:0] {IDLE, SINGLE, BCAST, RESP} state_t;

  localparam logic [NUM_SLICE-1:0] ALL_SLICES = {NUM_SLICE{1'b1}};
  localparam logic [7:0]           TMO_LAST   = 8'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [NUM_SLICE-1:0]   cyc_q, cyc_d;
  logic [NUM_SLICE-1:0]   stb_q, stb_d;
  logic [NUM_SLICE-1:0]   mask_q, mask_d;
  logic [7:0]             tmo_q, tmo_d;
  logic                   we_q, we_d;
  logic [3:0]             sel_q, sel_d;
  logic [11:0]            adr_q, adr_d;
  logic [31:0]            wdat_q, wdat_d;
  logic [31:0]            rdat_q, rdat_d;
  logic                   done_q, done_d;
  logic [15:0]            err_q, err_d;
  logic [3:0]             last_q, last_d;
  logic [3:0]             idx_q, idx_d;

  logic [31:0]            win_ofs;
  logic                   in_core;
  logic [3:0]             win_idx;
  logic [11:0]            reg_ofs;
  logic                   is_slice;
  logic                   is_ctrl;
  logic [NUM_SLICE-1:0]   win_onehot;

  logic [NUM_SLICE-1:0]   acks;
  logic [NUM_SLICE-1:0]   pend;
  logic [31:0]            slice_rdata;
  logic [3:0]             low_unacked;
  logic                   all_done;

  // Address decode: offset from the core base selects a slice window or the control window
  always_comb begin
    win_ofs  = wbs_adr_i - CORE_BASE;
    in_core  = (win_ofs[31:16] == 16'h0000);
    win_idx  = win_ofs[15:12];
    reg_ofs  = win_ofs[11:0];
    is_slice = in_core && ({28'd0, win_idx} < 32'(NUM_SLICE));
    is_ctrl  = in_core && (win_idx == 4'hF);
    for (int i = 0; i < NUM_SLICE; i++) begin
      win_onehot[i] = (win_idx == 4'(i));
    end
  end

  // Slice response helpers: qualified acks, read-data mux, lowest still-pending slice
  always_comb begin
    acks        = s_ack_i & stb_q;
    pend        = stb_q & ~acks;
    slice_rdata = '0;
    for (int i = 0; i < NUM_SLICE; i++) begin
      if (idx_q == 4'(i)) slice_rdata = s_dat_i[32*i +: 32];
    end
    low_unacked = '0;
    for (int i = NUM_SLICE - 1; i >= 0; i--) begin
      if (pend[i]) low_unacked = 4'(i);
    end
  end

  // Next-state logic for the transaction FSM and all captured state
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    mask_d   = mask_q;
    tmo_d    = tmo_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    done_d   = 1'b0;
    err_d    = err_q;
    last_d   = last_q;
    idx_d    = idx_q;
    all_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          rdat_d  = '0;
          state_d = RESP;
          if (is_slice) begin
            state_d = SINGLE;
            idx_d   = win_idx;
            cyc_d   = win_onehot;
            stb_d   = win_onehot;
            mask_d  = '0;
            tmo_d   = '0;
            we_d    = wbs_we_i;
            sel_d   = wbs_sel_i;
            adr_d   = wbs_adr_i[11:0];
            wdat_d  = wbs_dat_i;
          end else if (is_ctrl && reg_ofs == 12'h000 && wbs_we_i) begin
            state_d = BCAST;
            cyc_d   = ALL_SLICES;
            stb_d   = ALL_SLICES;
            mask_d  = '0;
            tmo_d   = '0;
            we_d    = 1'b1;
            sel_d   = wbs_sel_i;
            adr_d   = SPIKE_OFS;
            wdat_d  = wbs_dat_i;
          end else if (is_ctrl && reg_ofs == 12'h004 && wbs_we_i) begin
            done_d = 1'b1;
          end else if (is_ctrl && reg_ofs == 12'h008) begin
            if (wbs_we_i) begin
              err_d  = '0;
              last_d = '0;
            end else begin
              rdat_d = {err_q, 12'h000, last_q};
            end
          end
        end
      end

      SINGLE, BCAST: begin
        mask_d = mask_q | acks;
        stb_d  = pend;
        tmo_d  = tmo_q + 8'd1;
        if (state_q == SINGLE) all_done = (acks != '0);
        else                   all_done = (mask_d == ALL_SLICES);

        if (!wbs_cyc_i) begin
          state_d = IDLE;
          cyc_d   = '0;
          stb_d   = '0;
          mask_d  = '0;
        end else if (all_done) begin
          if (state_q == SINGLE) rdat_d = slice_rdata;
          else                   rdat_d = '0;
          state_d = RESP;
          cyc_d   = '0;
          stb_d   = '0;
          mask_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          last_d  = low_unacked;
          rdat_d  = '0;
          state_d = RESP;
          cyc_d   = '0;
          stb_d   = '0;
          mask_d  = '0;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      stb_q   <= '0;
      mask_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  assign wbs_ack_o    = (state_q == RESP);
  assign wbs_dat_o    = wbs_ack_o ? rdat_q : 32'h0;
  assign s_cyc_o      = cyc_q;
  assign s_stb_o      = stb_q;
  assign s_we_o       = we_q;
  assign s_sel_o      = sel_q;
  assign s_adr_o      = adr_q;
  assign s_dat_o      = wdat_q;
  assign picture_done = done_q;

endmodule

// File: tb/tb_neuron_core_fabric.sv
// tb/tb_neuron_core_fabric.sv - directed self-checking bench for neuron_core_fabric
module tb_neuron_core_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i, wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [7:0]   s_cyc_o, s_stb_o;
  logic         s_we_o;
  logic [3:0]   s_sel_o;
  logic [11:0]  s_adr_o;
  logic [31:0]  s_dat_o;
  logic [7:0]   s_ack_i;
  logic [255:0] s_dat_i;
  logic         picture_done;

  int n_checks = 0;
  int n_fail   = 0;

  neuron_core_fabric #(
    .NUM_SLICE (8),
    .CORE_BASE (32'h3000_0000),
    .SPIKE_OFS (12'h600),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .s_cyc_o      (s_cyc_o),
    .s_stb_o      (s_stb_o),
    .s_we_o       (s_we_o),
    .s_sel_o      (s_sel_o),
    .s_adr_o      (s_adr_o),
    .s_dat_o      (s_dat_o),
    .s_ack_i      (s_ack_i),
    .s_dat_i      (s_dat_i),
    .picture_done (picture_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = 4'hF;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
  endtask

  task automatic bus_idle();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  // one non-slice transaction: returns ack, data and picture_done seen in the cycle after the request
  task automatic ctrl_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           output logic ack, output logic [31:0] rd, output logic pd);
    req(adr, we, dat);
    tick();
    ack = wbs_ack_o;
    rd  = wbs_dat_o;
    pd  = picture_done;
    bus_idle();
    tick();
  endtask

  task automatic wait_ack(input int start, output int n);
    n = start;
    while (!wbs_ack_o && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic        ack, pd;
    logic [31:0] rd;
    logic [7:0]  exp_stb;
    int          n;

    rst     = 1'b1;
    bus_idle();
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    s_ack_i = '0;
    s_dat_i = '0;
    repeat (3) tick();

    // reset state
    check("rst_ack",  {31'd0, wbs_ack_o}, 32'd0);
    check("rst_dat",  wbs_dat_o, 32'd0);
    check("rst_stb",  {24'd0, s_stb_o}, 32'd0);
    check("rst_cyc",  {24'd0, s_cyc_o}, 32'd0);
    check("rst_adr",  {20'd0, s_adr_o}, 32'd0);
    check("rst_sdat", s_dat_o, 32'd0);
    check("rst_pd",   {31'd0, picture_done}, 32'd0);
    rst = 1'b0;
    tick();

    // single write to slice 3, ack two cycles after strobe; stray ack from slice 5 ignored
    req(32'h3000_3010, 1'b1, 32'hA5A5_0001);
    tick();
    check("wr3_stb",  {24'd0, s_stb_o}, 32'h08);
    check("wr3_adr",  {20'd0, s_adr_o}, 32'h010);
    check("wr3_we",   {31'd0, s_we_o}, 32'd1);
    check("wr3_sdat", s_dat_o, 32'hA5A5_0001);
    tick();
    s_ack_i = 8'h20;
    tick();
    check("wr3_stray_stb", {24'd0, s_stb_o}, 32'h08);
    check("wr3_stray_ack", {31'd0, wbs_ack_o}, 32'd0);
    s_ack_i = 8'h08;
    tick();
    s_ack_i = 8'h00;
    check("wr3_ack",     {31'd0, wbs_ack_o}, 32'd1);
    check("wr3_stb_off", {24'd0, s_stb_o}, 32'h00);
    bus_idle();
    tick();
    check("wr3_ack_one", {31'd0, wbs_ack_o}, 32'd0);

    // single read from slice 7
    req(32'h3000_7004, 1'b0, 32'h0);
    tick();
    check("rd7_stb", {24'd0, s_stb_o}, 32'h80);
    check("rd7_adr", {20'd0, s_adr_o}, 32'h004);
    check("rd7_we",  {31'd0, s_we_o}, 32'd0);
    s_ack_i = 8'h80;
    s_dat_i[32*7 +: 32] = 32'h1234_5678;
    s_dat_i[32*0 +: 32] = 32'hDEAD_BEEF;
    tick();
    s_ack_i = 8'h00;
    check("rd7_ack", {31'd0, wbs_ack_o}, 32'd1);
    check("rd7_dat", wbs_dat_o, 32'h1234_5678);
    bus_idle();
    tick();
    check("rd7_dat_idle", wbs_dat_o, 32'h0);

    // broadcast spike write with staggered acks
    req(32'h3000_F000, 1'b1, 32'h0000_002A);
    tick();
    check("bc_stb", {24'd0, s_stb_o}, 32'hFF);
    check("bc_adr", {20'd0, s_adr_o}, 32'h600);
    check("bc_dat", s_dat_o, 32'h0000_002A);
    for (int k = 0; k < 8; k++) begin
      s_ack_i = 8'(1 << k);
      tick();
      exp_stb = 8'hFF << (k + 1);
      if (k < 7) begin
        check("bc_stagger_stb", {24'd0, s_stb_o}, {24'd0, exp_stb});
        check("bc_stagger_ack", {31'd0, wbs_ack_o}, 32'd0);
      end else begin
        check("bc_final_ack", {31'd0, wbs_ack_o}, 32'd1);
        check("bc_final_stb", {24'd0, s_stb_o}, 32'h00);
      end
    end
    s_ack_i = 8'h00;
    bus_idle();
    tick();

    // read from slice 2 that never acks -> timeout
    req(32'h3000_2000, 1'b0, 32'h0);
    tick();
    check("to_stb", {24'd0, s_stb_o}, 32'h04);
    wait_ack(1, n);
    check("to_latency", 32'(n), 32'd17);
    check("to_dat", wbs_dat_o, 32'h0);
    check("to_stb_off", {24'd0, s_stb_o}, 32'h00);
    bus_idle();
    tick();
    ctrl_xfer(32'h3000_F008, 1'b0, 32'h0, ack, rd, pd);
    check("to_status_ack", {31'd0, ack}, 32'd1);
    check("to_status", rd, 32'h0001_0002);

    // ack in the very cycle the timeout expires counts as an ack
    req(32'h3000_1000, 1'b0, 32'h0);
    tick();
    repeat (15) tick();
    check("edge_stb", {24'd0, s_stb_o}, 32'h02);
    s_ack_i = 8'h02;
    s_dat_i[32*1 +: 32] = 32'hCAFE_0001;
    tick();
    s_ack_i = 8'h00;
    check("edge_ack", {31'd0, wbs_ack_o}, 32'd1);
    check("edge_dat", wbs_dat_o, 32'hCAFE_0001);
    bus_idle();
    tick();
    ctrl_xfer(32'h3000_F008, 1'b0, 32'h0, ack, rd, pd);
    check("edge_status", rd, 32'h0001_0002);

    // DONE pulse, unmapped accesses
    ctrl_xfer(32'h3000_F004, 1'b1, 32'h0, ack, rd, pd);
    check("done_ack", {31'd0, ack}, 32'd1);
    check("done_pd",  {31'd0, pd}, 32'd1);
    check("done_pd_off", {31'd0, picture_done}, 32'd0);
    ctrl_xfer(32'h3000_9000, 1'b1, 32'h1111_1111, ack, rd, pd);
    check("unmap9_ack", {31'd0, ack}, 32'd1);
    check("unmap9_dat", rd, 32'h0);
    ctrl_xfer(32'h3000_9000, 1'b0, 32'h0, ack, rd, pd);
    check("unmap9r_dat", rd, 32'h0);
    ctrl_xfer(32'h3000_F000, 1'b0, 32'h0, ack, rd, pd);
    check("bcast_rd_ack", {31'd0, ack}, 32'd1);
    check("bcast_rd_dat", rd, 32'h0);
    ctrl_xfer(32'h4000_0000, 1'b0, 32'h0, ack, rd, pd);
    check("outside_ack", {31'd0, ack}, 32'd1);
    ctrl_xfer(32'h3000_F008, 1'b0, 32'h0, ack, rd, pd);
    check("unmap_status", rd, 32'h0001_0002);

    // stb held after ack is a fresh request
    req(32'h3000_F004, 1'b1, 32'h0);
    tick();
    check("b2b_ack1", {31'd0, wbs_ack_o}, 32'd1);
    tick();
    check("b2b_gap", {31'd0, wbs_ack_o}, 32'd0);
    tick();
    check("b2b_ack2", {31'd0, wbs_ack_o}, 32'd1);
    check("b2b_pd2",  {31'd0, picture_done}, 32'd1);
    bus_idle();
    tick();

    // master drops cyc mid-transaction
    req(32'h3000_0000, 1'b1, 32'h5555_0000);
    tick();
    check("abort_stb", {24'd0, s_stb_o}, 32'h01);
    bus_idle();
    tick();
    check("abort_stb_off", {24'd0, s_stb_o}, 32'h00);
    check("abort_noack", {31'd0, wbs_ack_o}, 32'd0);
    tick();
    check("abort_noack2", {31'd0, wbs_ack_o}, 32'd0);
    ctrl_xfer(32'h3000_F008, 1'b0, 32'h0, ack, rd, pd);
    check("abort_status", rd, 32'h0001_0002);

    // reset during broadcast
    req(32'h3000_F000, 1'b1, 32'h0000_0007);
    tick();
    check("rstbc_stb", {24'd0, s_stb_o}, 32'hFF);
    rst = 1'b1;
    tick();
    check("rstbc_stb_off", {24'd0, s_stb_o}, 32'h00);
    check("rstbc_noack", {31'd0, wbs_ack_o}, 32'd0);
    rst = 1'b0;
    bus_idle();
    tick();
    check("rstbc_noack2", {31'd0, wbs_ack_o}, 32'd0);
    ctrl_xfer(32'h3000_F008, 1'b0, 32'h0, ack, rd, pd);
    check("rstbc_status", rd, 32'h0);

    // broadcast timeout with slices 4 and 6 silent
    req(32'h3000_F000, 1'b1, 32'h0000_0001);
    tick();
    s_ack_i = 8'hAF;
    tick();
    s_ack_i = 8'h00;
    check("bcto_stb", {24'd0, s_stb_o}, 32'h50);
    wait_ack(2, n);
    check("bcto_latency", 32'(n), 32'd17);
    check("bcto_dat", wbs_dat_o, 32'h0);
    bus_idle();
    tick();
    ctrl_xfer(32'h3000_F008, 1'b0, 32'h0, ack, rd, pd);
    check("bcto_status", rd, 32'h0001_0004);

    // STATUS write clears the error record
    ctrl_xfer(32'h3000_F008, 1'b1, 32'h0, ack, rd, pd);
    check("clr_ack", {31'd0, ack}, 32'd1);
    ctrl_xfer(32'h3000_F008, 1'b0, 32'h0, ack, rd, pd);
    check("clr_status", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
